seq_divider: RTL and testbench

- Multi-cycle unsigned integer divider built on a ripple-borrow subtract datapath. It is the inverse-direction companion to the team's ripple-carry full-adder chain.
- Restoring algorithm, one quotient bit per clock.
- Start/busy/done handshake; sits beside the ALU as the slow-path divide unit.

---
 rtl/div_pkg.sv | 13 +
 rtl/full_subtractor.sv | 13 +
 rtl/seq_divider.sv | 132 +++++++++++++
 tb/tb_seq_divider.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

    // Bits needed to count the WIDTH-1 .. 0 iterations (at least one bit).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit ripple-borrow subtractor cell: d = a - b - b_in, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
// Optional signed mode (is_signed port) is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dq, dsr, prem;
    logic [WIDTH:0]   shifted, sub_b, trial;
    logic [WIDTH+1:0] borrow;
    logic             take;
    logic [WIDTH-1:0] dq_nxt, prem_nxt, q_fix, r_fix;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic             neg_q, neg_r, neg_q_in, neg_r_in;
    logic             accept, div_zero, last_iter;

    assign accept    = (state == IDLE) && start;
    assign div_zero  = (divisor == '0);
    assign last_iter = (state == RUN) && (count == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    // Work on magnitudes; the sign flags ride along and fix up the results at capture.
    assign neg_q_in = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    assign neg_r_in = is_signed & dividend[WIDTH-1];
    assign dvd_mag  = neg_r_in ? -dividend : dividend;
    assign dsr_mag  = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
`else
    assign neg_q_in = 1'b0;
    assign neg_r_in = 1'b0;
    assign dvd_mag  = dividend;
    assign dsr_mag  = divisor;
`endif

    // Trial subtraction: shifted partial remainder minus divisor through the borrow chain.
    assign shifted   = {prem, dq[WIDTH-1]};
    assign sub_b     = {1'b0, dsr};
    assign borrow[0] = 1'b0;

    generate
        for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
            full_subtractor u_fs (
                .a     (shifted[i]),
                .b     (sub_b[i]),
                .b_in  (borrow[i]),
                .d     (trial[i]),
                .b_out (borrow[i+1])
            );
        end
    endgenerate

    // trial[WIDTH] is always 0 when no borrow occurs, so the remainder fits in WIDTH bits.
    assign take     = ~borrow[WIDTH+1] & ~trial[WIDTH];
    assign prem_nxt = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dq_nxt   = {dq[WIDTH-2:0], take};
    assign q_fix    = neg_q ? -dq_nxt : dq_nxt;
    assign r_fix    = neg_r ? -prem_nxt : prem_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = div_zero ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                if (count == '0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dq    <= dvd_mag;
            dsr   <= dsr_mag;
            prem  <= '0;
            count <= CW'(WIDTH - 1);
            neg_q <= neg_q_in;
            neg_r <= neg_r_in;
        end else if (state == RUN) begin
            dq    <= dq_nxt;
            prem  <= prem_nxt;
            count <= count - 1'b1;
        end
    end

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && div_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (last_iter) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): vector table, handshake/reset sequences, random model check.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] dividend, divisor;
    logic         is_signed;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .is_signed   (is_signed),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         dz, sgn;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller sits at a negedge; start is seen by the next posedge (edge 0).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Returns the number of edges after the current sample point until done is seen.
    task automatic wait_done(input string name, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
        end
        if (lat < 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    task automatic run_case(input string tag, input vec_t v);
        int lat, bcnt;
        launch(v.a, v.b, v.sgn);
        wait_done(tag, lat, bcnt);
        check({tag, "_lat"},  lat,  v.dz ? 0 : W);
        check({tag, "_busy"}, bcnt, v.dz ? 0 : W);
        check({tag, "_q"},    quotient,    v.q);
        check({tag, "_r"},    remainder,   v.r);
        check({tag, "_dz"},   div_by_zero, v.dz);
        @(negedge clk);
        check({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        vec_t tbl[$];
        int   lat, bcnt, extra;
        logic [W-1:0] ra, rb;

        tbl.push_back('{a:100, b:7,   q:14,    r:2,   dz:0, sgn:0});
        tbl.push_back('{a:255, b:1,   q:255,   r:0,   dz:0, sgn:0});
        tbl.push_back('{a:5,   b:9,   q:0,     r:5,   dz:0, sgn:0});
        tbl.push_back('{a:0,   b:3,   q:0,     r:0,   dz:0, sgn:0});
        tbl.push_back('{a:255, b:255, q:1,     r:0,   dz:0, sgn:0});
        tbl.push_back('{a:42,  b:0,   q:8'hFF, r:42,  dz:1, sgn:0});
        tbl.push_back('{a:200, b:7,   q:28,    r:4,   dz:0, sgn:0});
        tbl.push_back('{a:128, b:128, q:1,     r:0,   dz:0, sgn:0});
        tbl.push_back('{a:254, b:255, q:0,     r:254, dz:0, sgn:0});
`ifdef SEQ_DIVIDER_SIGNED_EN
        tbl.push_back('{a:8'hF9, b:8'h02, q:8'hFD, r:8'hFF, dz:0, sgn:1});
        tbl.push_back('{a:8'h80, b:8'hFF, q:8'h80, r:8'h00, dz:0, sgn:1});
        tbl.push_back('{a:8'h07, b:8'hFE, q:8'hFD, r:8'h01, dz:0, sgn:1});
        tbl.push_back('{a:8'hF0, b:8'h00, q:8'hFF, r:8'hF0, dz:1, sgn:1});
`endif

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; is_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q",    quotient, 0);
        check("rst_r",    remainder, 0);
        check("rst_dz",   div_by_zero, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_case("basic", tbl[0]);

        // A second start during RUN must be ignored and the first result delivered.
        launch(100, 7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        dividend = 9; divisor = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", lat, bcnt);
        check("ignore_lat", lat, W - 3);
        check("ignore_q", quotient, 14);
        check("ignore_r", remainder, 2);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        check("ignore_no_second", extra, 0);

        // Reset in the middle of a divide discards it entirely.
        launch(200, 7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_q", quotient, 0);
        check("midrst_r", remainder, 0);
        check("midrst_dz", div_by_zero, 1'b0);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("midrst_no_done", extra, 0);

        // Table cases run back to back: each start lands in the cycle right after done.
        foreach (tbl[i]) run_case($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(1, (1 << W) - 1));
            launch(ra, rb, 1'b0);
            wait_done("rand", lat, bcnt);
            check($sformatf("rand_q_%0d/%0d", ra, rb), quotient, ra / rb);
            check($sformatf("rand_r_%0d/%0d", ra, rb), remainder, ra % rb);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
